// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   ps2_state_e    receiver FSM states
//   ps2_err_t      sticky error flag bundle
//   PS2_FRAME_BITS start + 8 data + parity + stop
//   PS2_BREAK/EXT  scan-code prefixes for downstream decoders
`timescale 1ns/1ps
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, RECV, CHECK} ps2_state_e;

  typedef struct packed {
    logic parity;
    logic frame;
    logic overflow;
  } ps2_err_t;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;

  // Odd parity over data+parity bit: the XOR of all nine bits must be 1.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: scan-code pop handshake between the receiver and the bus
// register.
//   o_data   head byte (0 when empty)
//   o_valid  FIFO non-empty
//   o_count  occupancy
//   i_ready  pop request; a pop happens on o_valid && i_ready
`timescale 1ns/1ps
interface ps2_rx_fifo_if #(parameter int CNT_W = 5);
  logic [7:0]       o_data;
  logic             o_valid;
  logic [CNT_W-1:0] o_count;
  logic             i_ready;

  modport master (output o_data, output o_valid, output o_count, input i_ready);
  modport slave  (input o_data, input o_valid, input o_count, output i_ready);
endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO.
//   push_i/din_i   write request and data
//   pop_i          read request (ignored when empty)
//   dout_o         head entry, 0 when empty
//   full_o/empty_o status, count_o occupancy
// A push into a full FIFO succeeds when a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with scan-code FIFO.
//   clk, rst          system clock, synchronous active-high reset
//   PS2_CLK/PS2_DATA  raw asynchronous keyboard pins
//   bus               pop handshake (o_data/o_valid/o_count/i_ready)
//   i_clr_err         pulse clearing the sticky error flags
//   o_parity_err, o_frame_err, o_overflow  sticky error flags
//   o_irq             level interrupt while data is pending
`timescale 1ns/1ps
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           PS2_CLK,
  input  logic           PS2_DATA,
  ps2_rx_fifo_if.master  bus,
  input  logic           i_clr_err,
  output logic           o_parity_err,
  output logic           o_frame_err,
  output logic           o_overflow,
  output logic           o_irq
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]    ck_sync_q, dt_sync_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  ps2_state_e    state_q;
  logic [3:0]    bitcnt_q;
  logic [9:0]    shift_q;
  logic [TW-1:0] tmo_q;
  ps2_err_t      err_q, err_set, err_d;

  logic ck_s, dt_s, fall, tmo_hit;
  logic push_req, pop, full, empty;

  // Two-flop synchronisers, preset to the idle-bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
    end else begin
      ck_sync_q <= {ck_sync_q[0], PS2_CLK};
      dt_sync_q <= {dt_sync_q[0], PS2_DATA};
    end
  end
  assign ck_s = ck_sync_q[1];
  assign dt_s = dt_sync_q[1];

  // Clock de-glitch: fcnt_q counts consecutive samples that disagree with
  // the filtered level; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (ck_s == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= ck_s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end
  assign fall = filt_prev_q & ~filt_q;

  assign tmo_hit  = (state_q == RECV) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign push_req = (state_q == CHECK) && shift_q[9] && odd_parity_ok(shift_q[8:0]);
  assign pop      = ~empty & bus.i_ready;

  always_comb begin
    err_set.frame    = ((state_q == IDLE) && fall && dt_s) || tmo_hit ||
                       ((state_q == CHECK) && !shift_q[9]);
    err_set.parity   = (state_q == CHECK) && shift_q[9] && !odd_parity_ok(shift_q[8:0]);
    err_set.overflow = push_req && full && !pop;
    // Set wins over a same-cycle clear.
    err_d = (i_clr_err ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (fall && !dt_s) begin
            state_q  <= RECV;
            bitcnt_q <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shift_q  <= {dt_s, shift_q[9:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            tmo_q    <= '0;
            if (bitcnt_q == 4'(PS2_FRAME_BITS - 2)) state_q <= CHECK;
          end else if (tmo_hit) begin
            state_q <= IDLE;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        CHECK:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .din_i   (shift_q[7:0]),
    .pop_i   (pop),
    .dout_o  (bus.o_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (bus.o_count)
  );

  assign bus.o_valid  = ~empty;
  assign o_irq        = ~empty;
  assign o_parity_err = err_q.parity;
  assign o_frame_err  = err_q.frame;
  assign o_overflow   = err_q.overflow;
endmodule
